// File: rtl/min_max_ctrl_if.sv
// Bundles the board-side controls (switches, selector, raw buttons) and the
// registered operand outputs that feed min_max_top.
interface min_max_ctrl_if #(
    parameter int VALSIZE = 4
);
    logic [VALSIZE-1:0] sw_i;
    logic [1:0]         sel_i;
    logic               load_i;
    logic               inc_i;
    logic               dec_i;
    logic [1:0]         com_o;
    logic [VALSIZE-1:0] min_o;
    logic [VALSIZE-1:0] max_o;
    logic [VALSIZE-1:0] val_o;
    logic               osc_o;
    logic               err_o;

    // Board / stimulus side: drives the controls, observes the operands.
    modport master (
        output sw_i, sel_i, load_i, inc_i, dec_i,
        input  com_o, min_o, max_o, val_o, osc_o, err_o
    );

    // Controller side.
    modport slave (
        input  sw_i, sel_i, load_i, inc_i, dec_i,
        output com_o, min_o, max_o, val_o, osc_o, err_o
    );
endinterface

// File: rtl/min_max_ctrl.sv
// Control stage for min_max_top: synchronises and debounces the load/inc/dec
// buttons, turns accepted presses into one-cycle pulses, maintains the
// com/min/max/value operand registers with min<=max checking, and generates
// the low-duty dimming oscillation.
module min_max_ctrl #(
    parameter int VALSIZE    = 4,
    parameter int DEBOUNCE   = 4,
    parameter int OSC_PERIOD = 8,
    parameter int OSC_DUTY   = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    min_max_ctrl_if.slave bus
);

    // The debounce counter only ever holds 0..DEBOUNCE-1.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int OW = $clog2(OSC_PERIOD);
    localparam logic [VALSIZE-1:0] VAL_TOP = '1;

    // Button bit order throughout: [0] load, [1] inc, [2] dec.
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    db;
    logic [2:0]    db_d;
    logic [CW-1:0] db_cnt [3];
    logic [2:0]    pulse;
    logic          load_p;
    logic          inc_p;
    logic          dec_p;
    logic [OW-1:0] osc_cnt;

    assign raw = {bus.dec_i, bus.inc_i, bus.load_i};

    // Two-flop synchronisers plus the delayed debounced level for edge detection.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1   <= '0;
            s2   <= '0;
            db_d <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_d <= db;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db <= '0;
            for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (s2[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CW'(DEBOUNCE - 1)) begin
                    db[b]     <= s2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // One pulse per accepted rising level; falling levels are ignored.
    assign pulse  = db & ~db_d;
    assign load_p = pulse[0];
    assign inc_p  = pulse[1];
    assign dec_p  = pulse[2];

    // Operand registers. sw_i/sel_i are quasi-static and sampled directly:
    // the operator sets them well before the debounced load pulse arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.com_o <= 2'b00;
            bus.min_o <= '0;
            bus.max_o <= VAL_TOP;
            bus.err_o <= 1'b0;
        end else if (load_p) begin
            case (bus.sel_i)
                2'b00: begin
                    if (bus.sw_i <= bus.max_o) begin
                        bus.min_o <= bus.sw_i;
                        bus.err_o <= 1'b0;
                    end else begin
                        bus.err_o <= 1'b1;
                    end
                end
                2'b01: begin
                    if (bus.sw_i >= bus.min_o) begin
                        bus.max_o <= bus.sw_i;
                        bus.err_o <= 1'b0;
                    end else begin
                        bus.err_o <= 1'b1;
                    end
                end
                2'b10: bus.err_o <= 1'b0;
                default: begin
                    bus.com_o <= bus.sw_i[1:0];
                    bus.err_o <= 1'b0;
                end
            endcase
        end
    end

    // Displayed value: a value load overrides inc/dec; inc+dec together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.val_o <= '0;
        end else if (load_p && bus.sel_i == 2'b10) begin
            bus.val_o <= bus.sw_i;
        end else if (inc_p && !dec_p) begin
            if (bus.val_o != VAL_TOP) bus.val_o <= bus.val_o + 1'b1;
        end else if (dec_p && !inc_p) begin
            if (bus.val_o != '0) bus.val_o <= bus.val_o - 1'b1;
        end
    end

    // Free-running period counter; osc_o is high for the first OSC_DUTY counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            osc_cnt   <= '0;
            bus.osc_o <= 1'b0;
        end else begin
            osc_cnt   <= (osc_cnt == OW'(OSC_PERIOD - 1)) ? '0 : osc_cnt + 1'b1;
            bus.osc_o <= (osc_cnt < OW'(OSC_DUTY));
        end
    end

endmodule

// File: tb/tb_min_max_ctrl.sv
// Directed bench for min_max_ctrl (VALSIZE=4, DEBOUNCE=4, OSC_PERIOD=8,
// OSC_DUTY=1). Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_min_max_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   highs;

    always #5 clk = ~clk;

    min_max_ctrl_if #(.VALSIZE(4)) bus ();

    min_max_ctrl #(
        .VALSIZE(4), .DEBOUNCE(4), .OSC_PERIOD(8), .OSC_DUTY(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the given buttons 10 cycles, release, then let debounce settle.
    task automatic press(input logic l, input logic i, input logic d,
                         input logic [1:0] s, input logic [3:0] w);
        bus.sel_i  = s;
        bus.sw_i   = w;
        bus.load_i = l;
        bus.inc_i  = i;
        bus.dec_i  = d;
        cycles(10);
        bus.load_i = 1'b0;
        bus.inc_i  = 1'b0;
        bus.dec_i  = 1'b0;
        cycles(8);
    endtask

    function automatic logic [3:0] target(input logic [1:0] s);
        case (s)
            2'b00:   return bus.min_o;
            2'b01:   return bus.max_o;
            2'b10:   return bus.val_o;
            default: return {2'b00, bus.com_o};
        endcase
    endfunction

    // Load press with exact latency check: raw high before edge k, the
    // target must still be old after edge k+5 and new after edge k+6.
    task automatic load_latency(input string tag, input logic [1:0] s,
                                input logic [3:0] w, input logic [3:0] old_v,
                                input logic [3:0] new_v);
        bus.sel_i  = s;
        bus.sw_i   = w;
        bus.load_i = 1'b1;
        cycles(6);
        check({tag, "_before"}, target(s), old_v);
        cycles(1);
        check({tag, "_after"}, target(s), new_v);
        cycles(3);
        bus.load_i = 1'b0;
        cycles(8);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_com"}, bus.com_o, 8'h0);
        check({tag, "_min"}, bus.min_o, 8'h0);
        check({tag, "_max"}, bus.max_o, 8'hf);
        check({tag, "_val"}, bus.val_o, 8'h0);
        check({tag, "_osc"}, bus.osc_o, 8'h0);
        check({tag, "_err"}, bus.err_o, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sw_i   = '0;
        bus.sel_i  = '0;
        bus.load_i = 1'b0;
        bus.inc_i  = 1'b0;
        bus.dec_i  = 1'b0;
        rst_n      = 1'b0;
        cycles(3);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle: osc high after the first edge, then once every 8 cycles.
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            if (i == 0) check("osc_first", bus.osc_o, 8'h1);
            if (i == 1) check("osc_second", bus.osc_o, 8'h0);
            highs += int'(bus.osc_o);
        end
        check("osc_highs", 8'(highs), 8'd4);
        check("idle_max", bus.max_o, 8'hf);
        check("idle_err", bus.err_o, 8'h0);

        // Load sequence with exact latency.
        load_latency("lat_max", 2'b01, 4'd12, 4'd15, 4'd12);
        load_latency("lat_min", 2'b00, 4'd3, 4'd0, 4'd3);
        load_latency("lat_val", 2'b10, 4'd8, 4'd0, 4'd8);
        check("seq_min", bus.min_o, 8'd3);
        check("seq_max", bus.max_o, 8'd12);
        check("seq_val", bus.val_o, 8'd8);
        check("seq_err", bus.err_o, 8'h0);

        // Glitch filtering: 3 cycles rejected, 4 cycles accepted.
        bus.sel_i  = 2'b10;
        bus.sw_i   = 4'd5;
        bus.load_i = 1'b1;
        cycles(3);
        bus.load_i = 1'b0;
        cycles(10);
        check("glitch3_val", bus.val_o, 8'd8);
        bus.load_i = 1'b1;
        cycles(4);
        bus.load_i = 1'b0;
        cycles(10);
        check("glitch4_val", bus.val_o, 8'd5);

        // Consistency checking of min/max loads.
        press(1'b1, 1'b0, 1'b0, 2'b01, 4'd5);
        check("max5", bus.max_o, 8'd5);
        press(1'b1, 1'b0, 1'b0, 2'b00, 4'd9);
        check("rej_min9_min", bus.min_o, 8'd3);
        check("rej_min9_err", bus.err_o, 8'h1);
        press(1'b1, 1'b0, 1'b0, 2'b00, 4'd2);
        check("min2_min", bus.min_o, 8'd2);
        check("min2_err", bus.err_o, 8'h0);
        press(1'b1, 1'b0, 1'b0, 2'b01, 4'd1);
        check("rej_max1_max", bus.max_o, 8'd5);
        check("rej_max1_err", bus.err_o, 8'h1);
        press(1'b1, 1'b0, 1'b0, 2'b11, 4'b0110);
        check("com_load", bus.com_o, 8'd2);
        check("com_err", bus.err_o, 8'h0);

        // Saturation and simultaneous events.
        press(1'b1, 1'b0, 1'b0, 2'b10, 4'd15);
        press(1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
        check("inc_sat", bus.val_o, 8'd15);
        press(1'b1, 1'b0, 1'b0, 2'b10, 4'd0);
        press(1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        check("dec_sat", bus.val_o, 8'd0);
        press(1'b1, 1'b0, 1'b0, 2'b10, 4'd7);
        press(1'b0, 1'b1, 1'b1, 2'b10, 4'd0);
        check("inc_dec_cancel", bus.val_o, 8'd7);
        press(1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
        check("inc_7", bus.val_o, 8'd8);
        press(1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        check("dec_8", bus.val_o, 8'd7);
        press(1'b1, 1'b1, 1'b0, 2'b10, 4'd4);
        check("load_beats_inc", bus.val_o, 8'd4);
        press(1'b1, 1'b1, 1'b0, 2'b11, 4'd1);
        check("com_with_inc_com", bus.com_o, 8'd1);
        check("com_with_inc_val", bus.val_o, 8'd5);
        press(1'b1, 1'b0, 1'b0, 2'b00, 4'd9);
        check("rej_again_err", bus.err_o, 8'h1);
        press(1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        check("dec_keeps_err_val", bus.val_o, 8'd4);
        check("dec_keeps_err_err", bus.err_o, 8'h1);

        // Reset in the middle of a debounce interval.
        bus.sel_i  = 2'b10;
        bus.sw_i   = 4'd9;
        bus.load_i = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        cycles(3);
        check("midreset_hold_val", bus.val_o, 8'd0);
        rst_n = 1'b1;
        cycles(6);
        check("postreset_before", bus.val_o, 8'd0);
        cycles(1);
        check("postreset_after", bus.val_o, 8'd9);
        bus.load_i = 1'b0;
        cycles(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
